tri_scheduler: RTL and testbench

Frame-level sequencer that feeds the rasterizer one triangle at a time.
- On each frame_start it walks a triangle memory from address 0 to tri_count-1 and presents each triangle as vert1/vert2/vert3 with valid_tri.
- It flags the last triangle of the frame with obj_done, waits for the rasterizer to finish and swap buffers, then pulses frame_done.
- It sits between the scene/triangle BRAM and the rasterizer's valid_tri/ready_out handshake.

---
 rtl/raster_pkg.sv | 30 +++
 rtl/tri_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_tri_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Types and constants shared by the triangle scheduler, the rasterizer and the scene loader.
// Holds the packed-triangle layout and a helper that pulls one coordinate out of it.
package raster_pkg;

  localparam int COORD_W = 9;
  localparam int VERT_W  = 27;

  localparam int X_IDX = 2;
  localparam int Y_IDX = 1;
  localparam int Z_IDX = 0;

  localparam int V1_LSB = 0;
  localparam int V2_LSB = 27;
  localparam int V3_LSB = 54;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

  // field selects x/y/z via X_IDX/Y_IDX/Z_IDX; v_lsb selects the vertex slice
  function automatic logic [COORD_W-1:0] tri_coord(input logic [3*VERT_W-1:0] data,
                                                   input int v_lsb, input int field);
    return data[v_lsb + field*COORD_W +: COORD_W];
  endfunction

endpackage

// File: rtl/tri_scheduler.sv
// Frame-level sequencer: walks the triangle memory once per frame_start and hands
// triangles to the rasterizer over the valid_tri/ready_in handshake.
module tri_scheduler #(
  parameter int MAX_TRI = 1024,
  parameter int ADDR_W  = $clog2(MAX_TRI),
  parameter int ROM_LAT = 2,
  parameter int COORD_W = 9
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_start,
  input  logic [ADDR_W:0]      tri_count,
  output logic [ADDR_W-1:0]    tri_addr,
  input  logic [9*COORD_W-1:0] tri_data,
  output logic [COORD_W-1:0]   vert1 [3],
  output logic [COORD_W-1:0]   vert2 [3],
  output logic [COORD_W-1:0]   vert3 [3],
  output logic                 valid_tri,
  output logic                 obj_done,
  input  logic                 ready_in,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [15:0]          frame_count
);
  import raster_pkg::*;

  localparam int CNT_W = $clog2(ROM_LAT + 1);
  localparam logic [ADDR_W:0]    MAX_N     = (ADDR_W+1)'(MAX_TRI);
  localparam logic [CNT_W-1:0]   LAST_WAIT = CNT_W'(ROM_LAT);

  sched_state_t         state_r, state_s;
  logic [CNT_W-1:0]     wait_r, wait_s;
  logic [ADDR_W-1:0]    addr_r, addr_s;
  logic [ADDR_W:0]      n_r, n_s, n_req_s;
  logic [COORD_W-1:0]   v1_r [3], v1_s [3];
  logic [COORD_W-1:0]   v2_r [3], v2_s [3];
  logic [COORD_W-1:0]   v3_r [3], v3_s [3];
  logic                 valid_r, valid_s;
  logic                 obj_r, obj_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 overrun_r, overrun_s;
  logic                 drain_first_r, drain_first_s;
  logic [15:0]          fcount_r, fcount_s;

  assign n_req_s = (tri_count > MAX_N) ? MAX_N : tri_count;

  // Next-state and next-register values; every register defaults to holding.
  always_comb begin
    state_s       = state_r;
    wait_s        = wait_r;
    addr_s        = addr_r;
    n_s           = n_r;
    v1_s          = v1_r;
    v2_s          = v2_r;
    v3_s          = v3_r;
    valid_s       = valid_r;
    obj_s         = obj_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    fcount_s      = fcount_r;
    drain_first_s = 1'b0;
    if (frame_start && (state_r != IDLE)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          n_s = n_req_s;
          if (n_req_s == (ADDR_W+1)'(0)) begin
            state_s = DONE;
          end else begin
            addr_s  = ADDR_W'(0);
            wait_s  = CNT_W'(0);
            busy_s  = 1'b1;
            state_s = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        // the wait spans ROM_LAT+1 cycles so data from the registered address is settled
        if (wait_r == LAST_WAIT) begin
          for (int f = 0; f < 3; f++) begin
            v1_s[f] = tri_coord(tri_data, V1_LSB, f);
            v2_s[f] = tri_coord(tri_data, V2_LSB, f);
            v3_s[f] = tri_coord(tri_data, V3_LSB, f);
          end
          obj_s   = ({1'b0, addr_r} == (n_r - (ADDR_W+1)'(1)));
          valid_s = 1'b1;
          state_s = PRESENT;
        end else begin
          wait_s = wait_r + CNT_W'(1);
        end
      end
      PRESENT: begin
        if (ready_in) begin
          valid_s = 1'b0;
          obj_s   = 1'b0;
          if (obj_r) begin
            drain_first_s = 1'b1;
            state_s       = DRAIN;
          end else begin
            addr_s  = addr_r + ADDR_W'(1);
            wait_s  = CNT_W'(0);
            state_s = FETCH;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      DRAIN: begin
        // rasterizer ready is registered, so its value on the entry cycle is stale
        if (!drain_first_r && ready_in) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        done_s   = 1'b1;
        fcount_s = fcount_r + 16'd1;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_r        <= CNT_W'(0);
      addr_r        <= ADDR_W'(0);
      n_r           <= (ADDR_W+1)'(0);
      v1_r          <= '{default: COORD_W'(0)};
      v2_r          <= '{default: COORD_W'(0)};
      v3_r          <= '{default: COORD_W'(0)};
      valid_r       <= 1'b0;
      obj_r         <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      overrun_r     <= 1'b0;
      drain_first_r <= 1'b0;
      fcount_r      <= 16'd0;
    end else begin
      wait_r        <= wait_s;
      addr_r        <= addr_s;
      n_r           <= n_s;
      v1_r          <= v1_s;
      v2_r          <= v2_s;
      v3_r          <= v3_s;
      valid_r       <= valid_s;
      obj_r         <= obj_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      overrun_r     <= overrun_s;
      drain_first_r <= drain_first_s;
      fcount_r      <= fcount_s;
    end
  end

  assign tri_addr    = addr_r;
  assign vert1       = v1_r;
  assign vert2       = v2_r;
  assign vert3       = v3_r;
  assign valid_tri   = valid_r;
  assign obj_done    = obj_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;
  assign overrun     = overrun_r;
  assign frame_count = fcount_r;

endmodule

// File: tb/tb_tri_scheduler.sv
// Bench for tri_scheduler: an event-timeline model of the frame sequence is checked
// against the DUT every cycle, with directed scenarios and randomized frames.
module tb_tri_scheduler;
  localparam int MAX_TRI = 1024;
  localparam int ADDR_W  = 10;
  localparam int ROM_LAT = 2;
  localparam int NEVER   = 32'h7FFF_FFFF;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_in, frame_start, ready_in;
  logic [ADDR_W:0]   tri_count;
  logic [ADDR_W-1:0] tri_addr;
  logic [80:0]       tri_data;
  logic [8:0]        vert1 [3], vert2 [3], vert3 [3];
  logic              valid_tri, obj_done, busy, frame_done, overrun;
  logic [15:0]       frame_count;

  tri_scheduler #(.MAX_TRI(MAX_TRI), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .COORD_W(9)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start), .tri_count(tri_count),
    .tri_addr(tri_addr), .tri_data(tri_data), .vert1(vert1), .vert2(vert2), .vert3(vert3),
    .valid_tri(valid_tri), .obj_done(obj_done), .ready_in(ready_in), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .frame_count(frame_count)
  );

  // triangle memory with ROM_LAT cycles of read latency
  logic [80:0] mem [MAX_TRI];
  logic [80:0] rom_pipe [ROM_LAT];
  always @(posedge clk_in) begin
    rom_pipe[0] <= mem[tri_addr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign tri_data = rom_pipe[ROM_LAT-1];

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] fld(input logic [80:0] d, input int v, input int f);
    return d[v*27 + f*9 +: 9];
  endfunction

  // model: frame timeline expressed as scheduled cycle numbers
  bit model_ok = 1'b0;
  bit m_pending, m_draining, m_overrun, exp_valid;
  int m_k, m_n, m_valid_at, m_drain_from, m_done_at, m_idle_from;
  int m_busy_from, m_busy_until, m_fcount, req_n;
  // observations of the DUT used by the directed literal checks
  int start_cyc, first_valid_cyc, last_done_cyc, done_cnt = 0;
  int obs_hs_count, obs_hs_first, obs_hs_last;
  logic [8:0] pin_v1x, pin_v1z, pin_v3x, pin_v3z;

  // compare process: check this cycle's outputs, then advance the model on this cycle's inputs
  always @(negedge clk_in) begin
    if (model_ok) begin
      exp_valid = m_pending && (cyc >= m_valid_at);
      if (cyc == m_done_at) m_fcount = (m_fcount + 1) % 65536;
      chk("valid_tri", 32'(valid_tri), 32'(exp_valid));
      chk("tri_addr", 32'(tri_addr), 32'(m_k));
      chk("frame_done", 32'(frame_done), 32'(cyc == m_done_at));
      chk("frame_count", 32'(frame_count), 32'(m_fcount));
      chk("busy", 32'(busy), 32'(cyc >= m_busy_from && cyc < m_busy_until));
      chk("overrun", 32'(overrun), 32'(m_overrun));
      if (exp_valid) begin
        chk("obj_done", 32'(obj_done), 32'(m_k == m_n - 1));
        for (int f = 0; f < 3; f++) begin
          chk("vert1", 32'(vert1[f]), 32'(fld(mem[m_k], 0, f)));
          chk("vert2", 32'(vert2[f]), 32'(fld(mem[m_k], 1, f)));
          chk("vert3", 32'(vert3[f]), 32'(fld(mem[m_k], 2, f)));
        end
      end
      if (valid_tri === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_tri === 1'b1 && ready_in) begin
        if (obs_hs_count == 0) obs_hs_first = int'(tri_addr);
        obs_hs_last = int'(tri_addr);
        obs_hs_count++;
        if (tri_addr == 10'd1) begin
          pin_v1x = vert1[2]; pin_v1z = vert1[0]; pin_v3x = vert3[2]; pin_v3z = vert3[0];
        end
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (rst_in) begin
      model_ok = 1'b1;
      m_pending = 1'b0; m_draining = 1'b0; m_overrun = 1'b0;
      m_k = 0; m_n = 0; m_fcount = 0; m_done_at = -1; m_idle_from = 0;
      m_busy_from = 0; m_busy_until = 0;
    end else if (model_ok) begin
      if (exp_valid && ready_in) begin
        if (m_k == m_n - 1) begin
          m_pending = 1'b0; m_draining = 1'b1; m_drain_from = cyc + 2;
        end else begin
          m_k++; m_valid_at = cyc + ROM_LAT + 2;
        end
      end else if (m_draining && cyc >= m_drain_from && ready_in) begin
        m_draining = 1'b0; m_done_at = cyc + 2; m_idle_from = cyc + 2; m_busy_until = cyc + 2;
      end
      if (frame_start) begin
        if (cyc >= m_idle_from) begin
          req_n = int'(tri_count);
          m_n = (req_n > MAX_TRI) ? MAX_TRI : req_n;
          start_cyc = cyc; first_valid_cyc = -1; obs_hs_count = 0;
          if (m_n == 0) begin
            m_done_at = cyc + 2; m_idle_from = cyc + 2;
          end else begin
            m_k = 0; m_pending = 1'b1; m_valid_at = cyc + ROM_LAT + 2;
            m_busy_from = cyc + 1; m_busy_until = NEVER; m_idle_from = NEVER;
          end
        end else begin
          m_overrun = 1'b1;
        end
      end
    end
    cyc++;
  end

  bit rand_ready = 1'b0, rand_start = 1'b0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_frame(input int n);
    tri_count = (ADDR_W+1)'(n);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0 = done_cnt;
    int b = 0;
    while (done_cnt == d0 && b < budget) begin
      if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
      if (rand_start) begin
        tri_count = (ADDR_W+1)'($urandom_range(0, 15));
        frame_start = ($urandom_range(0, 15) == 0);
      end
      step();
      b++;
    end
    frame_start = 1'b0;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s: no frame_done within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_in = 1'b1; frame_start = 1'b0; ready_in = 1'b0; tri_count = '0;
    for (int i = 0; i < MAX_TRI; i++) mem[i] = 81'({$urandom(), $urandom(), $urandom()});
    mem[1] = {9'h1FF, 9'h000, 9'h0AA, 27'd0, 9'd5, 9'd6, 9'd7};
    repeat (3) step();
    rst_in = 1'b0;
    step();
    chk("rst_valid", 32'(valid_tri), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_addr", 32'(tri_addr), 32'd0);

    // three triangles, rasterizer always ready
    ready_in = 1'b1;
    start_frame(3);
    wait_done(200, "t1_done");
    chk("t1_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd4);
    chk("t1_hs_count", 32'(obs_hs_count), 32'd3);
    chk("t1_hs_first", 32'(obs_hs_first), 32'd0);
    chk("t1_hs_last", 32'(obs_hs_last), 32'd2);
    chk("t1_count", 32'(frame_count), 32'd1);
    chk("t1_pin_v1x", 32'(pin_v1x), 32'd5);
    chk("t1_pin_v1z", 32'(pin_v1z), 32'd7);
    chk("t1_pin_v3x", 32'(pin_v3x), 32'h1FF);
    chk("t1_pin_v3z", 32'(pin_v3z), 32'h0AA);

    // rasterizer stalls for 10 cycles while a triangle is presented
    ready_in = 1'b0;
    start_frame(2);
    b = 0;
    while (valid_tri !== 1'b1 && b < 20) begin step(); b++; end
    chk("t2_valid_seen", 32'(valid_tri), 32'd1);
    repeat (10) step();
    ready_in = 1'b1;
    wait_done(200, "t2_done");
    chk("t2_hs_count", 32'(obs_hs_count), 32'd2);

    // empty frame
    start_frame(0);
    wait_done(20, "t3_done");
    chk("t3_done_lat", 32'(last_done_cyc - start_cyc), 32'd2);
    chk("t3_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    chk("t3_count", 32'(frame_count), 32'd3);

    // frame_start mid-frame and on the DONE cycle is dropped
    chk("t4_overrun_before", 32'(overrun), 32'd0);
    start_frame(4);
    while (cyc < start_cyc + 3) step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    while (cyc < start_cyc + 19) step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    wait_done(200, "t4_done");
    chk("t4_done_lat", 32'(last_done_cyc - start_cyc), 32'd20);
    chk("t4_hs_count", 32'(obs_hs_count), 32'd4);
    chk("t4_overrun", 32'(overrun), 32'd1);
    start_frame(1);
    wait_done(200, "t4_next_done");
    chk("t4_count", 32'(frame_count), 32'd5);

    // drain: stale ready on entry, then low for 5 cycles before rising
    start_frame(2);
    while (cyc < start_cyc + 10) step();
    ready_in = 1'b0;
    while (cyc < start_cyc + 15) step();
    ready_in = 1'b1;
    wait_done(200, "t5_done");
    chk("t5_done_lat", 32'(last_done_cyc - start_cyc), 32'd17);

    // reset during the fetch of the second triangle
    start_frame(3);
    while (cyc < start_cyc + 6) step();
    rst_in = 1'b1; step(); rst_in = 1'b0;
    chk("t6_valid", 32'(valid_tri), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(tri_addr), 32'd0);
    chk("t6_count", 32'(frame_count), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    step();
    start_frame(3);
    wait_done(200, "t6_done");
    chk("t6_hs_first", 32'(obs_hs_first), 32'd0);
    chk("t6_hs_count", 32'(obs_hs_count), 32'd3);

    // oversized request clamps to the memory capacity
    rand_ready = 1'b1;
    start_frame(MAX_TRI + 5);
    wait_done(30000, "t7_done");
    chk("t7_hs_count", 32'(obs_hs_count), 32'(MAX_TRI));
    chk("t7_hs_last", 32'(obs_hs_last), 32'(MAX_TRI - 1));
    chk("t7_count", 32'(frame_count), 32'd2);

    // randomized frames with random ready, tri_count noise and stray frame_start
    rand_start = 1'b1;
    for (int i = 0; i < 25; i++) begin
      start_frame($urandom_range(0, 9));
      wait_done(3000, "rand_done");
    end
    rand_start = 1'b0; rand_ready = 1'b0; ready_in = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
